// File: rtl/prescaler_lib.sv
// Shared constants of the prescaler family; the period meter reuses its counter width.
package prescaler_lib;
  localparam int COUNTER_WIDTH = 32;
endpackage

// File: rtl/tick_period_meter_pkg.sv
// Types shared by the tick period meter and its comparator.
package tick_period_meter_lib;
  import prescaler_lib::COUNTER_WIDTH;

  typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;
  typedef logic [COUNTER_WIDTH-1:0] period_t;

  localparam period_t CNT_MAX = '1;
endpackage

// File: rtl/tick_period_cmp.sv
// Combinational unsigned |a-b| <= TOL test; max-min ordering avoids any wrap.
module tick_period_cmp #(
  parameter int COUNTER_WIDTH = 32,
  parameter int TOL           = 0
) (
  input  logic [COUNTER_WIDTH-1:0] a,
  input  logic [COUNTER_WIDTH-1:0] b,
  output logic                     match
);
  localparam logic [COUNTER_WIDTH-1:0] TOL_W = COUNTER_WIDTH'(TOL);

  logic [COUNTER_WIDTH-1:0] diff;

  assign diff  = (a >= b) ? (a - b) : (b - a);
  assign match = (diff <= TOL_W);
endmodule

// File: rtl/tick_period_meter.sv
// Measures clk cycles between consecutive tick_i strobes; reports period, lock and overflow.
module tick_period_meter
  import tick_period_meter_lib::*;
#(
  parameter int COUNTER_WIDTH = prescaler_lib::COUNTER_WIDTH,
  parameter int LOCK_COUNT    = 4,
  parameter int TOL           = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     tick_i,
  output logic [COUNTER_WIDTH-1:0] period_o,
  output logic                     valid_o,
  output logic                     locked_o,
  output logic                     overflow_o
);
  localparam logic [COUNTER_WIDTH-1:0] MAX    = '1;
  localparam logic [7:0]               LOCK_N = 8'(LOCK_COUNT);

  state_t                   state, state_nxt;
  logic [COUNTER_WIDTH-1:0] cnt, prev_period;
  logic [7:0]               match_cnt, match_inc;
  logic                     first, in_tol, at_max;

  tick_period_cmp #(.COUNTER_WIDTH(COUNTER_WIDTH), .TOL(TOL)) u_cmp (
    .a    (cnt),
    .b    (prev_period),
    .match(in_tol)
  );

  assign at_max    = (cnt == MAX);
  assign match_inc = (match_cnt >= LOCK_N) ? LOCK_N : match_cnt + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!en) state_nxt = IDLE;
    else begin
      case (state)
        IDLE:    state_nxt = ARM;
        ARM:     if (tick_i) state_nxt = MEASURE;
        MEASURE: if (!tick_i && at_max) state_nxt = ARM;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      prev_period <= '0;
      period_o    <= '0;
      match_cnt   <= '0;
      first       <= 1'b0;
      valid_o     <= 1'b0;
      locked_o    <= 1'b0;
      overflow_o  <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      if (!en) begin
        // period_o deliberately survives a disable so the last result stays readable
        cnt        <= '0;
        match_cnt  <= '0;
        first      <= 1'b0;
        locked_o   <= 1'b0;
        overflow_o <= 1'b0;
      end else begin
        case (state)
          ARM: begin
            if (tick_i) begin
              cnt   <= COUNTER_WIDTH'(1);
              first <= 1'b1;
            end
          end
          MEASURE: begin
            if (tick_i) begin
              period_o    <= cnt;
              valid_o     <= 1'b1;
              prev_period <= cnt;
              cnt         <= COUNTER_WIDTH'(1);
              first       <= 1'b0;
              if (first) begin
                match_cnt <= '0;
              end else if (in_tol) begin
                match_cnt <= match_inc;
                if (match_inc == LOCK_N) locked_o <= 1'b1;
              end else begin
                match_cnt <= '0;
                locked_o  <= 1'b0;
              end
            end else if (at_max) begin
              // saturated without a tick: drop lock and re-arm; cnt holds at MAX
              overflow_o <= 1'b1;
              locked_o   <= 1'b0;
              match_cnt  <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_tick_period_meter.sv
// Scoreboard bench: two meters (TOL=0 and TOL=1) share stimulus and are checked against a timestamp model.
module tb_tick_period_meter;
  localparam int    W    = 8;
  localparam int    LOCK = 4;
  localparam longint MAXP = 255;

  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, tick = 1'b0;
  logic [W-1:0] per [2];
  logic vld [2], lkd [2], ovf [2];

  always #5 clk = ~clk;

  tick_period_meter #(.COUNTER_WIDTH(W), .LOCK_COUNT(LOCK), .TOL(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .tick_i(tick),
    .period_o(per[0]), .valid_o(vld[0]), .locked_o(lkd[0]), .overflow_o(ovf[0]));

  tick_period_meter #(.COUNTER_WIDTH(W), .LOCK_COUNT(LOCK), .TOL(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .tick_i(tick),
    .period_o(per[1]), .valid_o(vld[1]), .locked_o(lkd[1]), .overflow_o(ovf[1]));

  typedef struct {int period; bit locked; bit ovf;} exp_t;
  exp_t q0[$], q1[$];
  int total = 0, bad = 0;

  // model: enabled/armed flags, timestamp of last tick, list of periods since arming
  longint cyc = 0;
  bit     live [2], have_t0 [2], m_ovf [2], m_lk [2];
  longint t0 [2];
  int     lastp [2];
  int     hist0[$], hist1[$];

  task automatic chk(input string name, input int i, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s dut%0d: got %0d expected %0d at %0t", name, i, act, exp, $time);
    end
  endtask

  function automatic bit lock_of(input int h[$], input int tol);
    int k = 0;
    for (int j = h.size() - 1; j > 0; j--) begin
      int d = (h[j] > h[j-1]) ? h[j] - h[j-1] : h[j-1] - h[j];
      if (d <= tol) k++;
      else break;
    end
    return k >= LOCK;
  endfunction

  task automatic step(input int i);
    int h[$];
    int tol = i;
    longint el;
    exp_t e;
    if (i == 0) h = hist0; else h = hist1;
    if (!rst_n) begin
      live[i] = 0; have_t0[i] = 0; h.delete(); m_ovf[i] = 0; m_lk[i] = 0; lastp[i] = 0;
      if (i == 0) q0.delete(); else q1.delete();
    end else if (!en) begin
      live[i] = 0; have_t0[i] = 0; h.delete(); m_ovf[i] = 0; m_lk[i] = 0;
    end else if (!live[i]) begin
      live[i] = 1;
    end else if (!have_t0[i]) begin
      if (tick) begin
        have_t0[i] = 1; t0[i] = cyc; h.delete();
      end
    end else begin
      el = cyc - t0[i];
      if (tick) begin
        h.push_back(int'(el));
        t0[i]    = cyc;
        m_lk[i]  = lock_of(h, tol);
        lastp[i] = int'(el);
        e = '{int'(el), m_lk[i], m_ovf[i]};
        if (i == 0) q0.push_back(e); else q1.push_back(e);
      end else if (el == MAXP) begin
        m_ovf[i] = 1; m_lk[i] = 0; have_t0[i] = 0; h.delete();
      end
    end
    if (i == 0) hist0 = h; else hist1 = h;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (rst_n) cyc++;
    for (int i = 0; i < 2; i++) step(i);
  end

  task automatic mon(input int i);
    exp_t e;
    bit   empty;
    if (vld[i]) begin
      empty = (i == 0) ? (q0.size() == 0) : (q1.size() == 0);
      if (empty) begin
        chk("valid_without_tick", i, 1, 0);
      end else begin
        if (i == 0) e = q0.pop_front(); else e = q1.pop_front();
        chk("valid_period", i, int'(per[i]), e.period);
        chk("valid_locked", i, int'(lkd[i]), int'(e.locked));
        chk("valid_overflow", i, int'(ovf[i]), int'(e.ovf));
      end
    end
    chk("locked_o", i, int'(lkd[i]), int'(m_lk[i]));
    chk("overflow_o", i, int'(ovf[i]), int'(m_ovf[i]));
    chk("period_hold", i, int'(per[i]), lastp[i]);
  endtask

  always @(negedge clk) begin
    if (rst_n) for (int i = 0; i < 2; i++) mon(i);
  end

  task automatic pulse(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      tick = (k == n - 1);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      tick = 1'b0;
    end
  endtask

  task automatic restart();
    @(negedge clk); en = 1'b0; tick = 1'b0;
    idle(2);
    en = 1'b1;
  endtask

  task automatic all_zero(input string name);
    for (int i = 0; i < 2; i++) begin
      chk({name, "_period"}, i, int'(per[i]), 0);
      chk({name, "_valid"}, i, int'(vld[i]), 0);
      chk({name, "_locked"}, i, int'(lkd[i]), 0);
      chk({name, "_overflow"}, i, int'(ovf[i]), 0);
    end
  endtask

  initial begin
    int base;
    #12;
    all_zero("reset");
    @(negedge clk); rst_n = 1'b1;

    // steady divide-by-10: lock on the 6th tick
    @(negedge clk); en = 1'b1;
    pulse(10);
    for (int k = 0; k < 7; k++) begin
      pulse(10);
      @(posedge clk); #1;
      chk("t1_valid", 0, int'(vld[0]), 1);
      chk("t1_locked", 0, int'(lkd[0]), (k >= 4) ? 1 : 0);
    end

    // glitch of 11 drops lock, five more periods of 10 relock
    pulse(11);
    @(posedge clk); #1;
    chk("t2_period", 0, int'(per[0]), 11);
    chk("t2_locked_drop", 0, int'(lkd[0]), 0);
    for (int k = 0; k < 5; k++) begin
      pulse(10);
      @(posedge clk); #1;
      chk("t2_relock", 0, int'(lkd[0]), (k == 4) ? 1 : 0);
    end

    // tolerance on dut_b
    restart();
    pulse(5);
    pulse(10); pulse(11); pulse(10); pulse(9); pulse(10);
    @(posedge clk); #1;
    chk("t3_locked_tol1", 1, int'(lkd[1]), 1);
    chk("t3_locked_tol0", 0, int'(lkd[0]), 0);

    // overflow
    restart();
    pulse(3);
    idle(300);
    chk("t4_overflow", 0, int'(ovf[0]), 1);
    chk("t4_overflow", 1, int'(ovf[1]), 1);
    pulse(10); pulse(10); pulse(10);
    @(posedge clk); #1;
    chk("t4_period", 0, int'(per[0]), 10);
    chk("t4_sticky", 0, int'(ovf[0]), 1);
    @(negedge clk); en = 1'b0; tick = 1'b0;
    idle(2);
    chk("t4_cleared", 0, int'(ovf[0]), 0);

    // en falling together with a tick
    en = 1'b1;
    pulse(4);
    repeat (6) pulse(7);
    idle(6);
    @(negedge clk); tick = 1'b1; en = 1'b0;
    @(posedge clk); #1;
    chk("t5_no_valid", 0, int'(vld[0]), 0);
    chk("t5_locked", 0, int'(lkd[0]), 0);
    chk("t5_period", 0, int'(per[0]), 7);
    pulse(3); pulse(3); pulse(3);
    idle(2);

    // async reset between ticks
    en = 1'b1;
    pulse(4); pulse(9); pulse(9);
    idle(3);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    all_zero("t6_async");
    #10;
    @(negedge clk); rst_n = 1'b1;
    pulse(6);
    @(posedge clk); #1;
    chk("t6_first_tick", 0, int'(vld[0]), 0);
    pulse(8);
    @(posedge clk); #1;
    chk("t6_period", 0, int'(per[0]), 8);

    // random mix: steady base with glitches, enable drops, long gaps
    base = $urandom_range(2, 15);
    repeat (150) begin
      int r = $urandom_range(0, 99);
      if (r < 5) begin
        @(negedge clk); en = 1'b0; tick = 1'($urandom_range(0, 1));
        idle($urandom_range(1, 3));
        en = 1'b1;
      end else if (r < 8) pulse($urandom_range(250, 300));
      else if (r < 30) pulse($urandom_range(1, 20));
      else if (r < 45) pulse(base + 1);
      else pulse(base);
    end
    idle(5);
    chk("queue_drained", 0, q0.size(), 0);
    chk("queue_drained", 1, q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tick_period_meter.md
Name: tick_period_meter

Overview:
- Receive-side counterpart to the prescaler: consumes the prescaler's single-cycle tick strobe and measures the interval between consecutive ticks in clk cycles.
- Reports each measured period, flags period stability (lock), and flags a missing or too-slow tick (overflow).
- Sits beside the prescaler in test/bring-up builds for self-checking of the divider output.

Parameters:
- COUNTER_WIDTH, prescaler_lib::COUNTER_WIDTH (32): width of the interval counter and of period_o.
- LOCK_COUNT, 4: consecutive in-tolerance period comparisons required to assert locked_o; range 1..255.
- TOL, 0: maximum allowed absolute difference (cycles) between consecutive periods that still counts as a match.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  measurement enable; low forces IDLE and clears status.
- tick_i  in  1  single-cycle strobe from the prescaler, synchronous to clk.
- period_o  out  COUNTER_WIDTH  last measured period in cycles.
- valid_o  out  1  one-cycle pulse; period_o updated this cycle.
- locked_o  out  1  period stable per LOCK_COUNT/TOL.
- overflow_o  out  1  sticky; interval counter saturated without a tick.

Behaviour:
- Reset values (async, rst_n=0): state IDLE, cnt 0, match_cnt 0, period_o 0, prev_period 0, valid_o 0, locked_o 0, overflow_o 0.
- FSM states: IDLE, ARM, MEASURE.
  - IDLE: en=1 -> ARM.
  - ARM: waits for the first tick. On tick_i=1: cnt<=1 -> MEASURE. No valid_o is issued for this tick.
  - MEASURE, no tick: cnt<=cnt+1.
  - MEASURE, tick_i=1: period_o<=cnt, valid_o<=1 (next cycle, one-cycle pulse), prev_period<=cnt, cnt<=1.
  - Any state, en=0: -> IDLE next cycle. Clears cnt, match_cnt, locked_o, overflow_o, valid_o. period_o holds its last value.
- en=0 has priority over a simultaneous tick_i; that tick is ignored.
- Period definition: ticks at cycles t0 and t1 give period t1-t0.
  - Tick every cycle -> 1.
  - Prescaler divide-by-N -> N.
- Latency: tick sampled at edge k -> valid_o and period_o visible after edge k (registered, one cycle).
- Overflow: in MEASURE with cnt == all-ones and no tick:
  - overflow_o<=1 (sticky until en=0), locked_o<=0, match_cnt<=0, cnt held, -> ARM.
  - The next tick re-arms; the period spanning the overflow is never reported.
- Lock (evaluated on each MEASURE tick):
  - First reported period after ARM has no predecessor: match_cnt<=0, no comparison.
  - Otherwise, if |cnt - prev_period| <= TOL: match_cnt increments, saturating at LOCK_COUNT.
  - Otherwise: match_cnt<=0 and locked_o<=0.
  - locked_o<=1 in the same cycle valid_o rises when the incremented match_cnt reaches LOCK_COUNT.
  - locked_o and period_o change together with valid_o.
- Arithmetic: the absolute difference is computed unsigned in COUNTER_WIDTH bits as max-min, so there is no wrap. cnt saturates and never wraps.
- Reset mid-measurement: immediate return to the reset values; no valid_o is emitted.

Decomposition:
- Package tick_period_meter_lib:
  - imports prescaler_lib::COUNTER_WIDTH;
  - defines typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;
  - defines typedef logic [COUNTER_WIDTH-1:0] period_t;
  - defines CNT_MAX constant (all-ones period_t).
- One sub-module, tick_period_cmp: combinational unsigned |a-b| <= TOL compare, parameterised on COUNTER_WIDTH and TOL.
- FSM, counters and output registers stay in tick_period_meter.

Test Plan:
1. Steady divide: en=1, tick every 10 cycles for 8 ticks (LOCK_COUNT=4, TOL=0).
   - First tick produces no valid_o; each of the remaining 7 ticks gives valid_o with period_o=10.
   - locked_o rises with the 6th tick's valid_o (4th matching comparison) and stays high.
2. Glitched period: lock on 10-cycle ticks, then one interval of 11.
   - valid_o with period_o=11; locked_o drops in that same cycle.
   - Relocks after 4 further matching periods of 10.
3. Tolerance: TOL=1, periods 10,11,10,9,10.
   - All comparisons match; locked_o high after the 4th comparison.
4. Overflow: COUNTER_WIDTH=8, one tick then none for 300 cycles.
   - overflow_o=1 after cnt reaches 255; state ARM; no valid_o.
   - Next ticks at 10-cycle spacing resume valid_o with period_o=10 while overflow_o stays 1.
   - en=0 clears overflow_o.
5. Enable/priority: tick_i and en falling in the same cycle.
   - No valid_o; IDLE; locked_o=0; period_o unchanged.
   - Ticks while en=0 produce nothing.
6. Async reset mid-count: assert rst_n=0 between ticks.
   - All outputs 0 immediately, without waiting for a clock edge.
   - After release with en=1, the first tick produces no valid_o; the second reports the correct period.
